mem_dma: RTL

- Bus-master initiator that copies a block of words from one memory region to another.
- Drives the Memory block's address, en and load_bar, and both samples and drives the shared 16-bit bus.
- Sits beside the CPU on the bus. Requests ownership via bus_req/bus_gnt, then alternates READ and WRITE cycles until done.

---
 rtl/mem_dma_pkg.sv | 28 ++
 rtl/mem_dma_addr_counter.sv | 30 +++
 rtl/mem_dma.sv | 129 ++++++++++++
 3 files changed

// File: rtl/mem_dma_pkg.sv
// mem_dma_pkg: shared definitions for the block-copy DMA initiator.
//   dma_state_e     - controller state encoding
//   ROM_TOP_DEFAULT - first writable address; lower destinations are ROM
//   dst_rejected()  - destination window legality check for a request
package mem_dma_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_READ  = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4,
    ST_ERR   = 3'd5
  } dma_state_e;

  localparam logic [15:0] ROM_TOP_DEFAULT = 16'h0100;

  // The last destination word is computed in 17 bits so a window that
  // runs past 16'hFFFF is caught instead of silently wrapping into ROM.
  function automatic logic dst_rejected(input logic [15:0] dst,
                                        input logic [15:0] cnt,
                                        input logic [15:0] rom_top);
    logic [16:0] last;
    last = {1'b0, dst} + {1'b0, cnt} - 17'd1;
    return (dst < rom_top) || (last > 17'h0_FFFF);
  endfunction

endpackage

// File: rtl/mem_dma_addr_counter.sv
// dma_addr_counter: 16-bit loadable address register with increment.
//   clk, reset     - clock, synchronous active-high reset (clears to 0)
//   load, load_val - parallel load (wins over inc)
//   inc            - increment by one, wrapping 16'hFFFF -> 16'h0000
//   q              - current value
module dma_addr_counter (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        inc,
  input  logic [15:0] load_val,
  output logic [15:0] q
);

  logic [15:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (load)     q_d = load_val;
    else if (inc) q_d = q_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) q_q <= '0;
    else       q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/mem_dma.sv
// mem_dma: bus-master DMA that copies count words from src to dst by
// alternating single-cycle READ and WRITE accesses on the shared bus.
//   clk, reset            - clock, synchronous active-high reset
//   start, src, dst, count - one-cycle request, operands sampled with it
//   busy, done, err       - status; done/err are one-cycle pulses
//   bus_req, bus_gnt      - bus ownership handshake with the arbiter
//   bus                   - shared data bus, driven only during WRITE
//   address, mem_en, load_bar - memory address / read enable / write strobe
// Every output is decoded from registered state; nothing combinational
// runs from an input to an output.
module mem_dma
  import mem_dma_pkg::*;
#(
  parameter logic [15:0] ROM_TOP = ROM_TOP_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] src,
  input  logic [15:0] dst,
  input  logic [15:0] count,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        bus_req,
  input  logic        bus_gnt,
  inout  wire  [15:0] bus,
  output logic [15:0] address,
  output logic        mem_en,
  output logic        load_bar
);

  dma_state_e  state_q, state_d;
  logic [15:0] remaining_q, remaining_d;
  logic [15:0] data_q, data_d;
  logic [15:0] src_q, dst_q;
  logic        src_ld, dst_ld, src_inc, dst_inc;

  dma_addr_counter u_src_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (src_ld),
    .inc      (src_inc),
    .load_val (src),
    .q        (src_q)
  );

  dma_addr_counter u_dst_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (dst_ld),
    .inc      (dst_inc),
    .load_val (dst),
    .q        (dst_q)
  );

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    data_d      = data_q;
    src_ld      = 1'b0;
    dst_ld      = 1'b0;
    src_inc     = 1'b0;
    dst_inc     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          src_ld      = 1'b1;
          dst_ld      = 1'b1;
          remaining_d = count;
          // A zero-length copy completes without looking at dst at all.
          if (count == 16'd0)                       state_d = ST_DONE;
          else if (dst_rejected(dst, count, ROM_TOP)) state_d = ST_ERR;
          else                                      state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (bus_gnt) state_d = ST_READ;
      end
      ST_READ: begin
        // Grant is deliberately not checked here: a started word pair
        // always finishes its WRITE.
        data_d  = bus;
        src_inc = 1'b1;
        state_d = ST_WRITE;
      end
      ST_WRITE: begin
        dst_inc     = 1'b1;
        remaining_d = remaining_q - 16'd1;
        if (remaining_q == 16'd1) state_d = ST_DONE;
        else if (bus_gnt)         state_d = ST_READ;
        else                      state_d = ST_REQ;
      end
      ST_DONE: state_d = ST_IDLE;
      ST_ERR:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      remaining_q <= '0;
      data_q      <= '0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      data_q      <= data_d;
    end
  end

  // Output decode. mem_en (READ) and the bus drive (WRITE) come from
  // mutually exclusive states, so the DMA never fights the memory.
  always_comb begin
    busy     = (state_q != ST_IDLE);
    done     = (state_q == ST_DONE);
    err      = (state_q == ST_ERR);
    bus_req  = (state_q == ST_REQ) || (state_q == ST_READ) ||
               (state_q == ST_WRITE);
    mem_en   = (state_q == ST_READ);
    load_bar = (state_q != ST_WRITE);
    address  = 16'h0000;
    if (state_q == ST_READ)       address = src_q;
    else if (state_q == ST_WRITE) address = dst_q;
  end

  assign bus = (state_q == ST_WRITE) ? data_q : 16'hzzzz;

endmodule
